vga_sync_gen: RTL and testbench

//  Downstream consumer of the pixel-enable pulse produced by enableN_gen.

---
 rtl/vga_sync_gen_pkg.sv | 28 ++
 rtl/vga_sync_gen_mod_counter.sv | 42 ++++
 rtl/vga_sync_gen.sv | 135 +++++++++++++
 tb/tb_vga_sync_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// vga_sync_gen_pkg: shared raster timing defaults and types
// 640x480@60 constants, FSM states and span helper
package vga_sync_gen_pkg;

    localparam int DEF_H_DISP = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_DISP = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int span_total(
        input int disp,
        input int fp,
        input int sync,
        input int bp
    );
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_mod_counter.sv
// vga_sync_gen_mod_counter: modulo-N counter with enable
// exposes next value so decode can align with the new count
module vga_sync_gen_mod_counter #(
    parameter int WIDTH   = 10,
    parameter int MODULUS = 800
) (
    input  logic             clk,
    input  logic             i_arst,
    input  logic             i_sclr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic at_last;

    assign at_last = (o_cnt == LAST);
    assign o_wrap  = i_en && at_last;

    // next count: clear wins, then wrap or increment
    always_comb begin
        o_nxt = o_cnt;
        if (i_sclr) begin
            o_nxt = '0;
        end else if (i_en) begin
            o_nxt = at_last ? '0 : o_cnt + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            o_cnt <= '0;
        end else begin
            o_cnt <= o_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster counters and sync/video/strobe decode
// advances one pixel per i_en pulse in the clk domain
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int H_DISP    = DEF_H_DISP,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_DISP    = DEF_V_DISP,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input  logic          clk,
    input  logic          i_arst,
    input  logic          i_sclr,
    input  logic          i_en,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_video_on,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_line_start,
    output logic          o_frame_start
);

    localparam int H_TOTAL = span_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_DISP, V_FP, V_SYNC, V_BP);

    localparam logic [XW-1:0] H_VIS  = XW'(H_DISP);
    localparam logic [XW-1:0] HS_BEG = XW'(H_DISP + H_FP);
    localparam logic [XW-1:0] HS_END = XW'(H_DISP + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_VIS  = YW'(V_DISP);
    localparam logic [YW-1:0] VS_BEG = YW'(V_DISP + V_FP);
    localparam logic [YW-1:0] VS_END = YW'(V_DISP + V_FP + V_SYNC);

    state_t        state_q;
    state_t        state_d;
    logic          h_en;
    logic          h_wrap;
    logic          v_en;
    logic          v_wrap;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          hsync_d;
    logic          vsync_d;
    logic          video_d;
    logic          line_d;
    logic          frame_d;

    assign h_en = (state_q == RUN) && i_en;
    assign v_en = h_en && h_wrap;

    vga_sync_gen_mod_counter #(
        .WIDTH   (XW),
        .MODULUS (H_TOTAL)
    ) u_hcnt (
        .clk    (clk),
        .i_arst (i_arst),
        .i_sclr (i_sclr),
        .i_en   (h_en),
        .o_cnt  (o_x),
        .o_nxt  (x_nxt),
        .o_wrap (h_wrap)
    );

    vga_sync_gen_mod_counter #(
        .WIDTH   (YW),
        .MODULUS (V_TOTAL)
    ) u_vcnt (
        .clk    (clk),
        .i_arst (i_arst),
        .i_sclr (i_sclr),
        .i_en   (v_en),
        .o_cnt  (o_y),
        .o_nxt  (y_nxt),
        .o_wrap (v_wrap)
    );

    // next state and decode of the post-edge counter values
    always_comb begin
        state_d = state_q;
        hsync_d = o_hsync;
        vsync_d = o_vsync;
        video_d = o_video_on;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (i_en) begin
            state_d = RUN;
            video_d = (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hsync_d = ((x_nxt >= HS_BEG) && (x_nxt < HS_END))
                      ? HSYNC_POL : ~HSYNC_POL;
            vsync_d = ((y_nxt >= VS_BEG) && (y_nxt < VS_END))
                      ? VSYNC_POL : ~VSYNC_POL;
            line_d  = (x_nxt == '0);
            frame_d = (x_nxt == '0) && (y_nxt == '0);
        end
        if (i_sclr) begin
            state_d = IDLE;
            hsync_d = ~HSYNC_POL;
            vsync_d = ~VSYNC_POL;
            video_d = 1'b0;
            line_d  = 1'b0;
            frame_d = 1'b0;
        end
    end

    // state and decoded output registers
    always_ff @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            state_q       <= IDLE;
            o_hsync       <= ~HSYNC_POL;
            o_vsync       <= ~VSYNC_POL;
            o_video_on    <= 1'b0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            state_q       <= state_d;
            o_hsync       <= hsync_d;
            o_vsync       <= vsync_d;
            o_video_on    <= video_d;
            o_line_start  <= line_d;
            o_frame_start <= frame_d;
        end
    end

    logic unused_v_wrap;
    assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench with raster position model
// small 8x6 raster, i_en pulses driven by the bench
module tb_vga_sync_gen;

    localparam int HD = 4;
    localparam int HF = 1;
    localparam int HS = 2;
    localparam int HB = 1;
    localparam int VD = 3;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;

    logic       clk;
    logic       i_arst;
    logic       i_sclr;
    logic       i_en;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_video_on;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_line_start;
    logic       o_frame_start;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // model: linear pixel position within the frame
    bit m_run;
    int m_pos;
    bit m_ls;
    bit m_fs;

    vga_sync_gen #(
        .H_DISP    (HD),
        .H_FP      (HF),
        .H_SYNC    (HS),
        .H_BP      (HB),
        .V_DISP    (VD),
        .V_FP      (VF),
        .V_SYNC    (VS),
        .V_BP      (VB),
        .HSYNC_POL (1'b0),
        .VSYNC_POL (1'b0),
        .XW        (10),
        .YW        (10)
    ) dut (
        .clk           (clk),
        .i_arst        (i_arst),
        .i_sclr        (i_sclr),
        .i_en          (i_en),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_video_on    (o_video_on),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_line_start  (o_line_start),
        .o_frame_start (o_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // model update on the same edges the DUT sees
    always @(posedge clk or posedge i_arst) begin
        if (i_arst) begin
            m_run = 0;
            m_pos = 0;
            m_ls  = 0;
            m_fs  = 0;
        end else begin
            m_ls = 0;
            m_fs = 0;
            if (i_sclr) begin
                m_run = 0;
                m_pos = 0;
            end else if (i_en) begin
                if (!m_run) begin
                    m_run = 1;
                    m_pos = 0;
                end else begin
                    m_pos = (m_pos + 1) % (HT * VT);
                end
                m_ls = (m_pos % HT) == 0;
                m_fs = (m_pos == 0);
            end
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            int ex;
            int ey;
            ex = m_pos % HT;
            ey = m_pos / HT;
            chk("x", int'(o_x), ex);
            chk("y", int'(o_y), ey);
            chk("video_on", int'(o_video_on),
                int'(m_run && ex < HD && ey < VD));
            chk("hsync", int'(o_hsync),
                int'(!(m_run && ex >= HD + HF && ex < HD + HF + HS)));
            chk("vsync", int'(o_vsync),
                int'(!(m_run && ey >= VD + VF && ey < VD + VF + VS)));
            chk("line_start", int'(o_line_start), int'(m_ls));
            chk("frame_start", int'(o_frame_start), int'(m_fs));
        end
    end

    task automatic step();
        @(negedge clk);
        i_en = 1'b1;
        @(negedge clk);
        i_en = 1'b0;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_arst = 1'b1;
        i_sclr = 1'b0;
        i_en   = 1'b0;
        idle(3);
        @(negedge clk);
        i_arst = 1'b0;
        chk_en = 1;

        // run a few pixels, then async reset mid-line
        step();
        step();
        step();
        idle(2);
        @(posedge clk);
        #3;
        i_arst = 1'b1;
        #1;
        chk("arst_x", int'(o_x), 0);
        chk("arst_y", int'(o_y), 0);
        chk("arst_video", int'(o_video_on), 0);
        chk("arst_hsync", int'(o_hsync), 1);
        chk("arst_vsync", int'(o_vsync), 1);
        @(negedge clk);
        i_arst = 1'b0;

        // first pixel after reset
        idle(2);
        step();
        chk("first_x", int'(o_x), 0);
        chk("first_video", int'(o_video_on), 1);
        chk("first_ls", int'(o_line_start), 1);
        chk("first_fs", int'(o_frame_start), 1);
        idle(1);
        chk("first_fs_drop", int'(o_frame_start), 0);
        chk("first_ls_drop", int'(o_line_start), 0);
        idle(8);

        // walk x across one line at one pixel per 10 clk
        for (int i = 1; i < HT; i++) begin
            step();
            chk("walk_x", int'(o_x), i);
            chk("walk_video", int'(o_video_on), (i < 4) ? 1 : 0);
            chk("walk_hsync", int'(o_hsync),
                (i == 5 || i == 6) ? 0 : 1);
            idle(8);
        end

        // line wrap (7,0) -> (0,1)
        step();
        chk("lwrap_x", int'(o_x), 0);
        chk("lwrap_y", int'(o_y), 1);
        chk("lwrap_ls", int'(o_line_start), 1);
        chk("lwrap_fs", int'(o_frame_start), 0);

        // advance to (0,4): vsync line
        repeat (24) step();
        chk("vs_y", int'(o_y), 4);
        chk("vs_low", int'(o_vsync), 0);
        repeat (7) step();
        chk("vs_low_end", int'(o_vsync), 0);
        step();
        chk("vs_y5", int'(o_y), 5);
        chk("vs_high", int'(o_vsync), 1);

        // frame wrap (7,5) -> (0,0)
        repeat (7) step();
        chk("pre_wrap_x", int'(o_x), 7);
        step();
        chk("fwrap_x", int'(o_x), 0);
        chk("fwrap_y", int'(o_y), 0);
        chk("fwrap_fs", int'(o_frame_start), 1);

        // hold mid-line with no enables
        repeat (3) step();
        idle(25);
        chk("hold_x", int'(o_x), 3);
        chk("hold_ls", int'(o_line_start), 0);

        // sclr beats a simultaneous enable
        @(negedge clk);
        i_sclr = 1'b1;
        i_en   = 1'b1;
        @(negedge clk);
        i_sclr = 1'b0;
        i_en   = 1'b0;
        #1;
        chk("sclr_x", int'(o_x), 0);
        chk("sclr_video", int'(o_video_on), 0);
        chk("sclr_hsync", int'(o_hsync), 1);
        chk("sclr_fs", int'(o_frame_start), 0);
        idle(3);
        step();
        chk("restart_fs", int'(o_frame_start), 1);
        chk("restart_video", int'(o_video_on), 1);

        // continuous enable across line and frame wraps
        @(negedge clk);
        i_en = 1'b1;
        repeat (60) @(negedge clk);
        i_en = 1'b0;
        idle(5);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
